// File: rtl/drum_mult_arbiter_pkg.sv
// Shared widths, requester-tag width helper and pipeline stage records for drum_mult_arbiter.
// Optional feature macro: DRUM_ARB_EXACT_EN (adds the exact-product flag to the S1 record).
package drum_arb_pkg;

  function automatic int id_width(input int num_req);
    return (num_req > 32'sd1) ? $clog2(num_req) : 32'sd1;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_K       = 8;
  localparam int DEF_N       = 16;
  localparam int DEF_M       = 16;
  localparam int DEF_ID_W    = id_width(DEF_NUM_REQ);

  // Stage records are sized by the package widths; the top's parameters default to them.
  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
`ifdef DRUM_ARB_EXACT_EN
    logic                exact;
`endif
    logic [DEF_N-1:0]    a;
    logic [DEF_M-1:0]    b;
  } s1_rec_t;

  typedef struct packed {
    logic                   valid;
    logic [DEF_ID_W-1:0]    id;
    logic [DEF_N+DEF_M-1:0] prod;
  } s2_rec_t;

endpackage

// File: rtl/drum_mult_arbiter_if.sv
// Requester operand channels and the shared result channel of drum_mult_arbiter.
// Optional feature macro: DRUM_ARB_EXACT_EN (adds req_exact).
interface drum_mult_arbiter_if
  import drum_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int N       = DEF_N,
  parameter int M       = DEF_M,
  parameter int ID_W    = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*M-1:0] req_b;
`ifdef DRUM_ARB_EXACT_EN
  logic [NUM_REQ-1:0]   req_exact;
`endif
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [N+M-1:0]       rsp_data;

  modport master (
`ifdef DRUM_ARB_EXACT_EN
    output req_exact,
`endif
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
`ifdef DRUM_ARB_EXACT_EN
    input  req_exact,
`endif
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/drum_mult_arbiter_chk.sv
// Protocol checker: a requester left waiting must keep req_valid and its operands stable.
module drum_mult_arbiter_chk #(
  parameter int NUM_REQ = 4,
  parameter int N       = 16,
  parameter int M       = 16
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_REQ-1:0]   valid,
  input logic [NUM_REQ-1:0]   ready,
  input logic [NUM_REQ*N-1:0] a,
  input logic [NUM_REQ*M-1:0] b
);
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (valid[i] && !ready[i]) |=>
        (valid[i] && $stable(a[i*N +: N]) && $stable(b[i*M +: M])));
  end
endmodule

// File: rtl/drum_mult_arbiter_drum.sv
// Signed DRUM approximate multiplier: K-bit leading windows with the LSB forced to 1,
// magnitudes taken as one's complement and the product bitwise-inverted on sign mismatch.
module drum_signed_mult #(
  parameter int N = 16,
  parameter int M = 16,
  parameter int K = 8
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] y
);
  localparam logic [K-1:0] ONE_K = {{(K-1){1'b0}}, 1'b1};

  logic [N-1:0]   mag_a_s;
  logic [M-1:0]   mag_b_s;
  logic [K-1:0]   win_a_s;
  logic [K-1:0]   win_b_s;
  logic [2*K-1:0] core_s;
  logic [N+M-1:0] wide_s;
  int             lead_a_s;
  int             lead_b_s;
  int             sh_a_s;
  int             sh_b_s;

  always_comb begin
    mag_a_s  = a[N-1] ? ~a : a;
    mag_b_s  = b[M-1] ? ~b : b;
    lead_a_s = 32'sd0;
    lead_b_s = 32'sd0;
    for (int i = 0; i < N; i++) begin
      lead_a_s = mag_a_s[i] ? i : lead_a_s;
    end
    for (int j = 0; j < M; j++) begin
      lead_b_s = mag_b_s[j] ? j : lead_b_s;
    end
    sh_a_s  = (lead_a_s >= K) ? (lead_a_s - K + 32'sd1) : 32'sd0;
    sh_b_s  = (lead_b_s >= K) ? (lead_b_s - K + 32'sd1) : 32'sd0;
    win_a_s = (lead_a_s >= K) ? (K'(mag_a_s >> sh_a_s) | ONE_K) : mag_a_s[K-1:0];
    win_b_s = (lead_b_s >= K) ? (K'(mag_b_s >> sh_b_s) | ONE_K) : mag_b_s[K-1:0];
    core_s  = (2*K)'(win_a_s) * (2*K)'(win_b_s);
    wide_s  = (N+M)'(core_s) << (sh_a_s + sh_b_s);
    y       = (a[N-1] ^ b[M-1]) ? ~wide_s : wide_s;
  end
endmodule

// File: rtl/drum_mult_arbiter_rr.sv
// Round-robin grant logic for drum_mult_arbiter; the search starts at rr_ptr and wraps.
module drum_rr_arbiter
  import drum_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] next_ptr_s;
  int              idx_s;

  // Walk from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx_s     = 32'sd0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx_s     = (int'(rr_ptr) + off) % NUM_REQ;
      grant_id  = valid[idx_s] ? ID_W'(idx_s) : grant_id;
      grant_any = grant_any | valid[idx_s];
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  assign next_ptr_s = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any && accept) begin
      rr_ptr <= next_ptr_s;
    end
  end
endmodule

// File: rtl/drum_mult_arbiter.sv
// Round-robin shared signed DRUM multiplier: S1 operand register, DRUM datapath, S2 result register.
// Optional feature macro: DRUM_ARB_EXACT_EN (per-request exact two's-complement product).
module drum_mult_arbiter
  import drum_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int K       = DEF_K,
  parameter int N       = DEF_N,
  parameter int M       = DEF_M,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input logic                Clock,
  input logic                Reset,
  drum_mult_arbiter_if.slave bus
);
  s1_rec_t            s1_r;
  s2_rec_t            s2_r;
  logic               s1_accept_s;
  logic               s2_accept_s;
  logic               xfer_s;
  logic               grant_any_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [N-1:0]       sel_a_s;
  logic [M-1:0]       sel_b_s;
  logic [N+M-1:0]     drum_y_s;
  logic [N+M-1:0]     prod_s;

  assign s2_accept_s = !s2_r.valid || bus.rsp_ready;
  assign s1_accept_s = !s1_r.valid || s2_accept_s;
  assign xfer_s      = grant_any_s && s1_accept_s && !Reset;

  drum_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (Clock),
    .rst      (Reset),
    .valid    (bus.req_valid),
    .accept   (s1_accept_s && !Reset),
    .grant    (grant_s),
    .grant_id (grant_id_s),
    .grant_any(grant_any_s)
  );

  // No requester is accepted while Reset is asserted.
  assign bus.req_ready = (s1_accept_s && !Reset) ? grant_s : '0;
  assign sel_a_s       = bus.req_a[int'(grant_id_s)*N +: N];
  assign sel_b_s       = bus.req_b[int'(grant_id_s)*M +: M];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_r <= '0;
    end else if (s1_accept_s) begin
      s1_r.valid <= xfer_s;
      s1_r.id    <= grant_id_s;
      s1_r.a     <= sel_a_s;
      s1_r.b     <= sel_b_s;
`ifdef DRUM_ARB_EXACT_EN
      s1_r.exact <= bus.req_exact[grant_id_s];
`endif
    end
  end

  drum_signed_mult #(.N(N), .M(M), .K(K)) u_mult (
    .a(s1_r.a),
    .b(s1_r.b),
    .y(drum_y_s)
  );

`ifdef DRUM_ARB_EXACT_EN
  logic signed [N+M-1:0] exact_s;
  assign exact_s = $signed(s1_r.a) * $signed(s1_r.b);
  assign prod_s  = s1_r.exact ? exact_s : drum_y_s;
`else
  assign prod_s  = drum_y_s;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s2_r <= '0;
    end else if (s2_accept_s) begin
      s2_r.valid <= s1_r.valid;
      s2_r.id    <= s1_r.id;
      s2_r.prod  <= prod_s;
    end
  end

  assign bus.rsp_valid = s2_r.valid;
  assign bus.rsp_id    = s2_r.id;
  assign bus.rsp_data  = s2_r.prod;

  drum_mult_arbiter_chk #(.NUM_REQ(NUM_REQ), .N(N), .M(M)) u_chk (
    .clk  (Clock),
    .rst  (Reset),
    .valid(bus.req_valid),
    .ready(bus.req_ready),
    .a    (bus.req_a),
    .b    (bus.req_b)
  );
endmodule

// File: tb/tb_drum_mult_arbiter.sv
// Scoreboard bench for drum_mult_arbiter: transfers push hand-computed products, a monitor pops on each result.
module tb_drum_mult_arbiter;
  localparam int NR    = 4;
  localparam int N     = 16;
  localparam int M     = 16;
  localparam int ID_W  = 2;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [N-1:0]   a;
    logic [M-1:0]   b;
    logic           exact;
    logic [N+M-1:0] exp;
  } vec_t;

  typedef struct packed {
    int             id;
    logic [N+M-1:0] data;
    int             t;
    bit             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  drum_mult_arbiter_if #(.NUM_REQ(NR), .N(N), .M(M), .ID_W(ID_W)) bus();

  drum_mult_arbiter #(.NUM_REQ(NR), .K(8), .N(N), .M(M), .ID_W(ID_W)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[NR][DEPTH];
  int   head[NR];
  int   tail[NR];
  exp_t sb[$];
  int   grant_log[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   lat_chk = 1'b1;
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) begin
      if (head[i] < tail[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Requester driver: notes handshakes at negedge, commits them and presents queue heads after the edge.
  initial begin
    logic [NR-1:0] xfer;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
`ifdef DRUM_ARB_EXACT_EN
    bus.req_exact = '0;
`endif
    forever begin
      @(negedge clk);
      xfer = rst ? '0 : (bus.req_valid & bus.req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (xfer[i]) begin
          sb.push_back('{id: i, data: vecs[i][head[i]].exp, t: cyc, lat: lat_chk});
          grant_log.push_back(i);
          head[i]++;
        end
      end
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (head[i] < tail[i]) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_a[i*N +: N]    = vecs[i][head[i]].a;
          bus.req_b[i*M +: M]    = vecs[i][head[i]].b;
`ifdef DRUM_ARB_EXACT_EN
          bus.req_exact[i]       = vecs[i][head[i]].exact;
`endif
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rsp: got id=%0d data=%0h, expected no response", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
        check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
        if (mon_e.lat) check("latency", 64'(cyc - mon_e.t), 64'd2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int r, input logic [N-1:0] a, input logic [M-1:0] b,
                      input logic ex, input logic [N+M-1:0] e);
    vecs[r][tail[r]] = '{a: a, b: b, exact: ex, exp: e};
    tail[r]++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || pending() || bus.rsp_valid) && n < 60) begin
      tick();
      n++;
    end
    check(name, 64'(n < 60), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    tick();

    // Single requests: exact small product, approximated large operand, sign inversion
    load(2, 16'd3, 16'd5, 1'b0, 32'd15);
    drain("drain_single_r2");
    load(0, 16'd1000, 16'd3, 1'b0, 32'd3012);
    drain("drain_single_r0");
    load(1, 16'hFFFD, 16'd5, 1'b0, 32'hFFFFFFF5);
    drain("drain_sign_r1");

    // Fairness from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_ptr_after_reset", 64'(dut.u_arb.rr_ptr), 64'd0);
    tick();
    grant_log.delete();
    load(0, 16'd7, 16'd9, 1'b0, 32'd63);
    load(0, 16'd100, 16'd2, 1'b0, 32'd200);
    load(1, 16'hFFFF, 16'd1, 1'b0, 32'hFFFFFFFF);
    load(1, 16'hFFFE, 16'hFFFD, 1'b0, 32'd2);
    load(2, 16'd300, 16'd1, 1'b0, 32'd302);
    load(2, 16'd255, 16'd255, 1'b0, 32'd65025);
    load(3, 16'd1000, 16'd1000, 1'b0, 32'd1008016);
    load(3, 16'd12, 16'hFFFC, 1'b0, 32'hFFFFFFDB);
    drain("drain_fairness");
    check("grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) check("grant_order", 64'(grant_log[i]), 64'(i % 4));
    end

    // Backpressure: results held stable, requesters blocked once both stages fill
    lat_chk = 1'b0;
    bus.rsp_ready = 1'b0;
    load(1, 16'h8000, 16'h7FFF, 1'b0, 32'hC07FBFFF);
    load(1, 16'd3, 16'd5, 1'b0, 32'd15);
    load(1, 16'd1000, 16'd3, 1'b0, 32'd3012);
    load(1, 16'hFFFD, 16'd5, 1'b0, 32'hFFFFFFF5);
    repeat (5) begin
      tick();
      if (bus.rsp_valid) check("bp_hold_data", 64'(bus.rsp_data), 64'hC07FBFFF);
    end
    check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_rsp_id", 64'(bus.rsp_id), 64'd1);
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    check("bp_in_flight", 64'(sb.size()), 64'd2);
    bus.rsp_ready = 1'b1;
    drain("drain_backpressure");
    lat_chk = 1'b1;

    // Reset with both stages full: in-flight products are discarded
    bus.rsp_ready = 1'b0;
    load(2, 16'd7, 16'd9, 1'b0, 32'd63);
    load(2, 16'd100, 16'd2, 1'b0, 32'd200);
    load(2, 16'd255, 16'd255, 1'b0, 32'd65025);
    repeat (5) tick();
    check("rs_pre_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("rs_pre_req_ready", 64'(bus.req_ready), 64'd0);
    check("rs_pre_rr_ptr", 64'(dut.u_arb.rr_ptr), 64'd3);
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    tick();
    check("rs_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rs_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rs_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rs_req_ready", 64'(bus.req_ready), 64'd0);
    check("rs_rr_ptr", 64'(dut.u_arb.rr_ptr), 64'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (6) tick();
    check("rs_post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rs_post_sb_empty", 64'(sb.size()), 64'd0);

`ifdef DRUM_ARB_EXACT_EN
    load(0, 16'd1000, 16'd3, 1'b1, 32'd3000);
    load(0, 16'd1000, 16'd3, 1'b0, 32'd3012);
    load(0, 16'hFFFD, 16'd5, 1'b1, 32'hFFFFFFF1);
    drain("drain_exact");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
